// File: rtl/mem_issue_queue_m.sv
// In-order issue queue for memory micro-ops: buffers dispatched loads/stores, captures late
// operands from the result bypass, drops branch-killed entries and issues one packet per cycle.
module mem_issue_queue_m #(
    parameter int unsigned WIDTH_QUEUE = 3,
    parameter int unsigned WIDTH_BRM   = 4,
    parameter int unsigned WIDTH_REG   = 5,
    parameter int unsigned WIDTH       = 1 + 7 + WIDTH_BRM + WIDTH_REG + 10 + 4 * 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wr,
    input  logic [WIDTH-1:0]       i_instr,
    input  logic [WIDTH_REG-1:0]   i_rs1,
    input  logic [WIDTH_REG-1:0]   i_rs2,
    input  logic                   i_rdy1,
    input  logic                   i_rdy2,
    input  logic [33+WIDTH_REG-1:0] i_bypass,
    input  logic [WIDTH_BRM-1:0]   i_brkill,
    input  logic [WIDTH_BRM-1:0]   i_brok,
    output logic [WIDTH-1:0]       o_instr,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int DEPTH   = 1 << WIDTH_QUEUE;
    localparam int LO_W    = WIDTH_REG + 138;  // {rd, pc, func, imm, op2, op1}
    localparam int BRM_LSB = LO_W;
    localparam int UOP_LSB = BRM_LSB + WIDTH_BRM;
    localparam int BYP_W   = 33 + WIDTH_REG;
    localparam logic [WIDTH_QUEUE:0] DEPTH_CNT = (WIDTH_QUEUE + 1)'(DEPTH);

    logic [WIDTH_QUEUE:0]   head_q, head_d, tail_q, tail_d, count;
    logic [WIDTH_QUEUE-1:0] head_idx, tail_idx;
    logic [DEPTH-1:0]       live_q, live_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [WIDTH_REG-1:0]   rs1_q [DEPTH];
    logic [WIDTH_REG-1:0]   rs1_d [DEPTH];
    logic [WIDTH_REG-1:0]   rs2_q [DEPTH];
    logic [WIDTH_REG-1:0]   rs2_d [DEPTH];
    logic [WIDTH_BRM-1:0]   brm_q [DEPTH];
    logic [WIDTH_BRM-1:0]   brm_d [DEPTH];
    logic [6:0]             uop_q [DEPTH];
    logic [6:0]             uop_d [DEPTH];
    logic [LO_W-1:0]        lo_q  [DEPTH];
    logic [LO_W-1:0]        lo_d  [DEPTH];

    logic                   byp_val, byp_hit, enq, issue, head_adv, head_kill, full, empty;
    logic [WIDTH_REG-1:0]   byp_tag;
    logic [31:0]            byp_data;
    logic [WIDTH_BRM-1:0]   in_brm;
    logic                   unused_val;

    assign byp_val    = i_bypass[BYP_W-1];
    assign byp_tag    = i_bypass[32 +: WIDTH_REG];
    assign byp_data   = i_bypass[31:0];
    assign byp_hit    = byp_val && (byp_tag != '0);
    assign in_brm     = i_instr[BRM_LSB +: WIDTH_BRM];
    assign unused_val = i_instr[WIDTH-1];

    assign head_idx = head_q[WIDTH_QUEUE-1:0];
    assign tail_idx = tail_q[WIDTH_QUEUE-1:0];
    assign count    = tail_q - head_q;
    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    assign o_full   = full;
    assign o_empty  = empty;
    assign enq      = i_wr && !full;

    // A head being killed this cycle is not issued; it turns dead and is skipped next cycle.
    assign head_kill = |(brm_q[head_idx] & i_brkill);
    assign issue     = !empty && live_q[head_idx] && rdy1_q[head_idx] && rdy2_q[head_idx]
                       && !head_kill;
    assign head_adv  = !empty && (issue || !live_q[head_idx]);

    assign o_instr = {issue, uop_q[head_idx], brm_q[head_idx] & ~i_brok, lo_q[head_idx]};

    assign head_d = head_q + {{WIDTH_QUEUE{1'b0}}, head_adv};
    assign tail_d = tail_q + {{WIDTH_QUEUE{1'b0}}, enq};

    always_comb begin
        live_d = live_q;
        rdy1_d = rdy1_q;
        rdy2_d = rdy2_q;
        rs1_d  = rs1_q;
        rs2_d  = rs2_q;
        brm_d  = brm_q;
        uop_d  = uop_q;
        lo_d   = lo_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (byp_hit && live_q[i] && !rdy1_q[i] && (rs1_q[i] == byp_tag)) begin
                rdy1_d[i]       = 1'b1;
                lo_d[i][31:0]   = byp_data;
            end
            if (byp_hit && live_q[i] && !rdy2_q[i] && (rs2_q[i] == byp_tag)) begin
                rdy2_d[i]       = 1'b1;
                lo_d[i][63:32]  = byp_data;
            end
            // Kill is judged on the pre-resolve mask, so kill wins over a same-bit resolve.
            if (|(brm_q[i] & i_brkill)) begin
                live_d[i] = 1'b0;
            end
            brm_d[i] = brm_q[i] & ~i_brok;
        end
        if (enq) begin
            live_d[tail_idx] = ~|(in_brm & i_brkill);
            brm_d[tail_idx]  = in_brm & ~i_brok;
            uop_d[tail_idx]  = i_instr[UOP_LSB +: 7];
            lo_d[tail_idx]   = i_instr[LO_W-1:0];
            rs1_d[tail_idx]  = i_rs1;
            rs2_d[tail_idx]  = i_rs2;
            rdy1_d[tail_idx] = i_rdy1;
            rdy2_d[tail_idx] = i_rdy2;
            if (!i_rdy1 && byp_hit && (i_rs1 == byp_tag)) begin
                rdy1_d[tail_idx]       = 1'b1;
                lo_d[tail_idx][31:0]   = byp_data;
            end
            if (!i_rdy2 && byp_hit && (i_rs2 == byp_tag)) begin
                rdy2_d[tail_idx]       = 1'b1;
                lo_d[tail_idx][63:32]  = byp_data;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_q <= '0;
            tail_q <= '0;
            live_q <= '0;
            rdy1_q <= '0;
            rdy2_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rs1_q[i] <= '0;
                rs2_q[i] <= '0;
                brm_q[i] <= '0;
                uop_q[i] <= '0;
                lo_q[i]  <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            live_q <= live_d;
            rdy1_q <= rdy1_d;
            rdy2_q <= rdy2_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            brm_q  <= brm_d;
            uop_q  <= uop_d;
            lo_q   <= lo_d;
        end
    end

endmodule

// File: tb/tb_mem_issue_queue_m.sv
// Randomised and directed bench for mem_issue_queue_m with a queue-level reference model
// feeding a scoreboard that a separate monitor drains.
module tb_mem_issue_queue_m;

    localparam int WB    = 4;
    localparam int WR    = 5;
    localparam int W     = 1 + 7 + WB + WR + 10 + 128;
    localparam int BW    = 33 + WR;
    localparam int DEPTH = 8;

    logic          clk, rst, wr, rdy1, rdy2, full, empty;
    logic [W-1:0]  instr, o_instr;
    logic [WR-1:0] rs1, rs2;
    logic [BW-1:0] byp;
    logic [WB-1:0] kill, ok;

    int checks   = 0;
    int failures = 0;

    mem_issue_queue_m dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_wr     (wr),
        .i_instr  (instr),
        .i_rs1    (rs1),
        .i_rs2    (rs2),
        .i_rdy1   (rdy1),
        .i_rdy2   (rdy2),
        .i_bypass (byp),
        .i_brkill (kill),
        .i_brok   (ok),
        .o_instr  (o_instr),
        .o_full   (full),
        .o_empty  (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        live, r1, r2;
        logic [4:0]  s1, s2;
        logic [3:0]  brm;
        logic [6:0]  uop;
        logic [4:0]  rd;
        logic [9:0]  pc;
        logic [31:0] func, imm, op2, op1;
    } ent_t;

    ent_t         mq[$];       // index 0 is the oldest held entry
    logic [W-1:0] exp_pkt[$];
    logic [2:0]   exp_st[$];   // {full, empty, val} per cycle

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one cycle of the queue, given the inputs currently applied.
    task automatic model_step();
        ent_t        e;
        logic        iss, pop, was_full, bv;
        logic [4:0]  tag;
        logic [31:0] data;
        bv = byp[BW-1];
        tag = byp[32 +: WR];
        data = byp[31:0];
        iss = 1'b0;
        pop = 1'b0;
        was_full = (mq.size() == DEPTH);
        if (mq.size() > 0) begin
            e = mq[0];
            iss = e.live && e.r1 && e.r2 && ((e.brm & kill) == 4'd0);
            pop = iss || !e.live;
            if (iss) exp_pkt.push_back({1'b1, e.uop, e.brm & ~ok, e.rd, e.pc, e.func, e.imm,
                                        e.op2, e.op1});
        end
        exp_st.push_back({was_full, mq.size() == 0, iss});
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            if (bv && tag != 0 && e.live) begin
                if (!e.r1 && e.s1 == tag) begin e.r1 = 1'b1; e.op1 = data; end
                if (!e.r2 && e.s2 == tag) begin e.r2 = 1'b1; e.op2 = data; end
            end
            if ((e.brm & kill) != 4'd0) e.live = 1'b0;
            e.brm = e.brm & ~ok;
            mq[i] = e;
        end
        if (pop) mq.delete(0);
        if (wr && !was_full) begin
            e.uop  = instr[153:147];
            e.brm  = instr[146:143] & ~ok;
            e.live = ((instr[146:143] & kill) == 4'd0);
            e.rd   = instr[142:138];
            e.pc   = instr[137:128];
            e.func = instr[127:96];
            e.imm  = instr[95:64];
            e.op2  = instr[63:32];
            e.op1  = instr[31:0];
            e.s1 = rs1; e.s2 = rs2; e.r1 = rdy1; e.r2 = rdy2;
            if (!rdy1 && bv && tag != 0 && rs1 == tag) begin e.r1 = 1'b1; e.op1 = data; end
            if (!rdy2 && bv && tag != 0 && rs2 == tag) begin e.r2 = 1'b1; e.op2 = data; end
            mq.push_back(e);
        end
    endtask

    task automatic step(input logic w, input logic [W-1:0] ins, input logic [4:0] s1,
                        input logic [4:0] s2, input logic r1, input logic r2,
                        input logic [BW-1:0] b, input logic [3:0] k, input logic [3:0] o);
        @(negedge clk);
        rst = 1'b0;
        wr = w; instr = ins; rs1 = s1; rs2 = s2; rdy1 = r1; rdy2 = r2;
        byp = b; kill = k; ok = o;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 5'd0, 5'd0, 1'b0, 1'b0, '0, 4'd0, 4'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        wr = 1'b0; instr = '0; rs1 = '0; rs2 = '0; rdy1 = 1'b0; rdy2 = 1'b0;
        byp = '0; kill = '0; ok = '0;
        mq.delete();
        exp_pkt.delete();
        exp_st.delete();
        #1;
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        chk("reset_instr", o_instr, '0);
        idle(1);
    endtask

    function automatic logic [W-1:0] mk(input logic [6:0] uop, input logic [3:0] brm,
                                        input logic [9:0] pc, input logic [31:0] op2,
                                        input logic [31:0] op1);
        return {1'b1, uop, brm, 5'd3, pc, 32'h0000_0033, 32'h0000_0010, op2, op1};
    endfunction

    function automatic logic [BW-1:0] bp(input logic [4:0] tag, input logic [31:0] data);
        return {1'b1, tag, data};
    endfunction

    // Monitor: per-cycle status plus in-order packets whenever the DUT issues.
    initial begin
        logic [2:0]   st;
        logic [W-1:0] ep;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && exp_st.size() > 0) begin
                st = exp_st.pop_front();
                chk("o_full", full, st[2]);
                chk("o_empty", empty, st[1]);
                chk("o_val", o_instr[W-1], st[0]);
                if (o_instr[W-1] || st[0]) begin
                    if (exp_pkt.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL issue_unexpected actual=%h required=none", o_instr);
                    end else begin
                        ep = exp_pkt.pop_front();
                        if (o_instr[W-1]) chk("o_instr", o_instr, ep);
                    end
                end
            end
        end
    end

    initial begin
        logic [W-1:0] ri;
        logic         r1, r2;
        rst = 1'b1;
        do_reset();

        // In-order ready loads.
        step(1, mk(7'h03, 0, 10'h10, 32'h2, 32'h1), 0, 0, 1, 1, '0, 0, 0);
        step(1, mk(7'h03, 0, 10'h14, 32'h4, 32'h3), 0, 0, 1, 1, '0, 0, 0);
        step(1, mk(7'h03, 0, 10'h18, 32'h6, 32'h5), 0, 0, 1, 1, '0, 0, 0);
        idle(3);

        // Store waiting on op2 blocks a younger ready load until the bypass.
        step(1, mk(7'h23, 0, 10'h20, 32'h0, 32'h100), 0, 7, 1, 0, '0, 0, 0);
        step(1, mk(7'h03, 0, 10'h24, 32'h8, 32'h9), 0, 0, 1, 1, '0, 0, 0);
        step(0, '0, 0, 0, 0, 0, bp(7, 32'hDEADBEEF), 0, 0);
        idle(3);

        // Fill, drop a write while full, then wake everything at once.
        for (int i = 0; i < DEPTH; i++)
            step(1, mk(7'h03, 0, 10'(10'h40 + i), 32'(i), 32'h0), 3, 0, 0, 1, '0, 0, 0);
        step(1, mk(7'h03, 0, 10'h99, 32'h99, 32'h99), 0, 0, 1, 1, '0, 0, 0);
        step(0, '0, 0, 0, 0, 0, bp(3, 32'hA5A5_0003), 0, 0);
        idle(10);

        // Branch kill leaves only the 0010 entry.
        step(1, mk(7'h03, 4'b0001, 10'h60, 32'h0, 32'h0), 4, 0, 0, 1, '0, 0, 0);
        step(1, mk(7'h03, 4'b0010, 10'h64, 32'h0, 32'h0), 4, 0, 0, 1, '0, 0, 0);
        step(1, mk(7'h03, 4'b0001, 10'h68, 32'h0, 32'h0), 4, 0, 0, 1, '0, 0, 0);
        step(0, '0, 0, 0, 0, 0, '0, 4'b0001, 0);
        step(0, '0, 0, 0, 0, 0, bp(4, 32'h44), 0, 0);
        idle(5);

        // Resolve clears a mask bit so a later kill on that bit spares the entry.
        step(1, mk(7'h03, 4'b0011, 10'h70, 32'h0, 32'h0), 5, 0, 0, 1, '0, 0, 0);
        step(0, '0, 0, 0, 0, 0, '0, 0, 4'b0010);
        step(0, '0, 0, 0, 0, 0, '0, 4'b0010, 0);
        step(0, '0, 0, 0, 0, 0, bp(5, 32'h55AA), 0, 0);
        idle(3);

        // Same-cycle wakeup at enqueue; tag 0 never wakes.
        step(1, mk(7'h03, 0, 10'h80, 32'h0, 32'h0), 9, 0, 0, 1, bp(9, 32'h55), 0, 0);
        idle(2);
        step(1, mk(7'h03, 0, 10'h84, 32'h0, 32'h0), 0, 0, 0, 1, bp(0, 32'h66), 0, 0);
        step(1, mk(7'h03, 0, 10'h88, 32'h0, 32'h0), 0, 0, 1, 1, '0, 0, 0);
        idle(3);

        // Reset with entries held.
        do_reset();

        for (int n = 0; n < 2500; n++) begin
            ri = {$urandom, $urandom, $urandom, $urandom, $urandom};
            r1 = ($urandom_range(0, 9) < 7);
            r2 = ($urandom_range(0, 9) < 7);
            step(($urandom_range(0, 9) < 6), ri,
                 r1 ? 5'd0 : 5'($urandom_range(1, 7)),
                 r2 ? 5'd0 : 5'($urandom_range(1, 7)), r1, r2,
                 ($urandom_range(0, 1) == 1) ? bp(5'($urandom_range(0, 7)), $urandom) : '0,
                 ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0,
                 ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0);
        end
        idle(4);
        #3;
        chk("scoreboard_drained", W'(exp_pkt.size() + exp_st.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
